mem_wb_unit: RTL and testbench

- Memory-access and write-back stage downstream of decode.
- Consumes the decode outputs (ALU result, `op2_regfile_to_mem`, `load`, `store`, `mem_to_reg`) plus pc+4, rd and reg_write.
- Drives a data-memory request/response interface.
- Produces the registered `wb_mux_out`, rd and write-enable that feed back into the decode-stage register file, and a stall back to the pipeline.

---
 rtl/rv32_mem_pkg.sv | 40 ++++
 rtl/load_store_align.sv | 51 +++++
 rtl/mem_wb_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_wb_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32 memory-access / write-back stage:
// FSM states, func3 load/store widths, write-back select codes.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    // Write-back mux; callers pass zero as load_data when no load result exists.
    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] pc4,
                                              input logic [31:0] load_data);
        case (sel)
            WB_ALU:  return alu;
            WB_LOAD: return load_data;
            WB_PC4:  return pc4;
            WB_ZERO: return 32'd0;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte-enables and lane replication,
// load byte/half extraction with sign or zero extension.
module load_store_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // NOTE: each output is given a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_wmask = 4'b1111;
        o_wdata = i_store_data;
        case (i_func3)
            F3_SB: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            F3_SH: begin
                o_wmask = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
            end
            F3_SW:   o_wmask = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_func3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {24'd0, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_data = {16'd0, w_half};
            F3_LW:   o_load_data = i_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory-access / write-back stage: data-memory handshake with timeout and registered write-back.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses without issuing a memory request.
module mem_wb_unit
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_out,
    input  logic [31:0] op2_regfile_to_mem,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  func3,
    input  logic [1:0]  mem_to_reg,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] wb_mux_out,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_valid,
    output logic        mem_err
);

    // Counter must reach TIMEOUT_CYCLES when a load handshakes on the last allowed REQ cycle.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e           r_state, w_state_next;
    logic [31:0]      r_addr, r_wdata, r_pc4;
    logic [2:0]       r_func3;
    logic [1:0]       r_m2r;
    logic [4:0]       r_rd;
    logic             r_reg_write, r_is_store;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_wb_mux_out;
    logic [4:0]       r_wb_rd;
    logic             r_wb_reg_write, r_wb_valid, r_mem_err;

    logic        w_in_req, w_busy, w_accept, w_is_mem, w_misalign, w_timeout;
    logic        w_capture, w_wb_load, w_wb_reg_write, w_mem_err;
    logic [31:0] w_wb_data, w_load_data, w_wdata;
    logic [4:0]  w_wb_rd;
    logic [3:0]  w_wmask;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_busy    = w_in_req || (r_state == ST_WAIT_RSP);
    assign w_accept  = valid_in && !w_busy;
    assign w_is_mem  = load || store;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        if (load)
            w_misalign = ((func3 == F3_LH || func3 == F3_LHU) && alu_out[0]) ||
                         (func3 == F3_LW && alu_out[1:0] != 2'b00);
        else if (store)
            w_misalign = (func3 == F3_SH && alu_out[0]) ||
                         (func3 == F3_SW && alu_out[1:0] != 2'b00);
    end
`else
    assign w_misalign = 1'b0;
`endif

    load_store_align u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_func3      (r_func3),
        .i_store_data (r_wdata),
        .i_rdata      (mem_rdata),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        w_wb_load      = 1'b0;
        w_wb_reg_write = 1'b0;
        w_wb_rd        = r_rd;
        w_wb_data      = 32'd0;
        w_mem_err      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_next = ST_IDLE;
                if (w_accept) begin
                    w_wb_rd   = rd_in;
                    w_wb_data = wb_select(mem_to_reg, alu_out, pc_plus4, 32'd0);
                    if (!w_is_mem) begin
                        w_wb_load      = 1'b1;
                        w_wb_reg_write = reg_write_in;
                    end else if (w_misalign) begin
                        w_state_next = ST_DONE;
                        w_wb_load    = 1'b1;
                        w_mem_err    = 1'b1;
                    end else begin
                        w_state_next = ST_REQ;
                        w_capture    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (r_is_store) begin
                        w_state_next = ST_DONE;
                        w_wb_load    = 1'b1;
                        w_wb_data    = wb_select(r_m2r, r_addr, r_pc4, 32'd0);
                    end else begin
                        w_state_next = ST_WAIT_RSP;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                    w_wb_load    = 1'b1;
                    w_mem_err    = 1'b1;
                    w_wb_data    = wb_select(r_m2r, r_addr, r_pc4, 32'd0);
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rvalid) begin
                    w_state_next   = ST_DONE;
                    w_wb_load      = 1'b1;
                    w_wb_reg_write = r_reg_write;
                    w_wb_data      = wb_select(r_m2r, r_addr, r_pc4, w_load_data);
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                    w_wb_load    = 1'b1;
                    w_mem_err    = 1'b1;
                    w_wb_data    = wb_select(r_m2r, r_addr, r_pc4, 32'd0);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_pc4          <= '0;
            r_func3        <= '0;
            r_m2r          <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_is_store     <= 1'b0;
            r_cnt          <= '0;
            r_wb_mux_out   <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_mem_err      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wb_valid     <= w_wb_load;
            r_wb_reg_write <= w_wb_reg_write;
            r_mem_err      <= w_mem_err;
            if (w_wb_load) begin
                r_wb_mux_out <= w_wb_data;
                r_wb_rd      <= w_wb_rd;
            end
            if (w_capture) begin
                r_addr      <= alu_out;
                r_wdata     <= op2_regfile_to_mem;
                r_pc4       <= pc_plus4;
                r_func3     <= func3;
                r_m2r       <= mem_to_reg;
                r_rd        <= rd_in;
                r_reg_write <= reg_write_in;
                r_is_store  <= store && !load;
                r_cnt       <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stall        = w_busy;
    assign mem_req      = w_in_req;
    assign mem_we       = w_in_req && r_is_store;
    assign mem_addr     = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata    = mem_we ? w_wdata : 32'd0;
    assign mem_wmask    = mem_we ? w_wmask : 4'd0;
    assign wb_mux_out   = r_wb_mux_out;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_valid     = r_wb_valid;
    assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Self-checking bench for mem_wb_unit: table-driven non-memory vectors, directed
// load/store/timeout/reset sequences, and randomized transactions against a behavioural model.
module tb_mem_wb_unit;

    localparam int TO = 4;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid_in, load, store, reg_write_in, mem_ready, mem_rvalid;
    logic [31:0] alu_out, op2_regfile_to_mem, pc_plus4, mem_rdata;
    logic [2:0]  func3;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd_in;
    logic        stall, mem_req, mem_we, wb_reg_write, wb_valid, mem_err;
    logic [31:0] mem_addr, mem_wdata, wb_mux_out;
    logic [3:0]  mem_wmask;
    logic [4:0]  wb_rd;

    int n_pass  = 0;
    int n_total = 0;

    mem_wb_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_in           (valid_in),
        .alu_out            (alu_out),
        .op2_regfile_to_mem (op2_regfile_to_mem),
        .load               (load),
        .store              (store),
        .func3              (func3),
        .mem_to_reg         (mem_to_reg),
        .pc_plus4           (pc_plus4),
        .rd_in              (rd_in),
        .reg_write_in       (reg_write_in),
        .stall              (stall),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wmask          (mem_wmask),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .mem_rvalid         (mem_rvalid),
        .wb_mux_out         (wb_mux_out),
        .wb_rd              (wb_rd),
        .wb_reg_write       (wb_reg_write),
        .wb_valid           (wb_valid),
        .mem_err            (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] m2r,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw);
        valid_in = 1'b1; load = ld; store = st; func3 = f3; mem_to_reg = m2r;
        alu_out = a; op2_regfile_to_mem = d; pc_plus4 = pc; rd_in = rd; reg_write_in = rw;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({stall, mem_req, mem_we, mem_err, wb_valid, wb_reg_write, mem_wmask, wb_rd}), 32'd0);
        check({name, "_addr"}, mem_addr, 32'd0);
        check({name, "_wdata"}, mem_wdata, 32'd0);
        check({name, "_wbdata"}, wb_mux_out, 32'd0);
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [31:0] exp_wb(input logic [1:0] m2r, input logic [31:0] alu,
                                           input logic [31:0] pc, input logic [31:0] ld);
        case (m2r)
            2'd0:    return alu;
            2'd1:    return ld;
            2'd2:    return pc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] b, h;
        int sh_b;
        sh_b = 8 * int'(addr[1:0]);
        b = (rdata >> sh_b) & 32'hFF;
        h = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return b - ((b & 32'h80) << 1);
            3'd4:    return b;
            3'd1:    return h - ((h & 32'h8000) << 1);
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd0) return 4'(1 << addr[1:0]);
        if (f3 == 3'd1) return addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit misaligned(input bit as_load, input logic [2:0] f3, input logic [31:0] addr);
        bit half_bad, word_bad;
        half_bad = (addr % 2) != 0;
        word_bad = (addr % 4) != 0;
        if (!TRAP) return 1'b0;
        if (as_load) return ((f3 == 3'd1 || f3 == 3'd5) && half_bad) || (f3 == 3'd2 && word_bad);
        return (f3 == 3'd1 && half_bad) || (f3 == 3'd2 && word_bad);
    endfunction

    // One randomized instruction, issued while the block is idle or in DONE.
    task automatic run_random(input int idx);
        logic        ld, st, is_load, is_store, rw, done, timed_out, in_wait;
        logic [2:0]  f3;
        logic [1:0]  m2r;
        logic [31:0] a, d, pc, rdata, ld_val;
        logic [4:0]  rd;
        int          kind, d_r, d_v, k, req_cnt, wait_cnt;
        string       t;
        t = $sformatf("rnd%0d", idx);
        kind = int'($urandom_range(0, 3));
        ld = (kind == 1) || (kind == 3);
        st = (kind == 2) || (kind == 3);
        f3 = 3'($urandom_range(0, 7));
        m2r = 2'($urandom_range(0, 3));
        a = $urandom; d = $urandom; pc = $urandom; rdata = $urandom;
        rd = 5'($urandom); rw = 1'($urandom);
        d_r = int'($urandom_range(0, 4));
        d_v = int'($urandom_range(0, 3));
        is_load = ld;
        is_store = st && !ld;

        drive(ld, st, f3, m2r, a, d, pc, rd, rw);
        step();
        valid_in = 1'b0;

        if (!ld && !st) begin
            check({t, "_nm_valid"}, 32'(wb_valid), 32'd1);
            check({t, "_nm_data"}, wb_mux_out, exp_wb(m2r, a, pc, 32'd0));
            check({t, "_nm_rd"}, 32'(wb_rd), 32'(rd));
            check({t, "_nm_we"}, 32'(wb_reg_write), 32'(rw));
            check({t, "_nm_req"}, 32'(mem_req), 32'd0);
            return;
        end

        if (misaligned(is_load, f3, a)) begin
            check({t, "_mis_req"}, 32'(mem_req), 32'd0);
            check({t, "_mis_err"}, 32'(mem_err), 32'd1);
            check({t, "_mis_valid"}, 32'(wb_valid), 32'd1);
            check({t, "_mis_we"}, 32'(wb_reg_write), 32'd0);
            return;
        end

        done = 1'b0; timed_out = 1'b0; in_wait = 1'b0;
        k = 0; req_cnt = 0; wait_cnt = 0;
        while (!done && k < 20) begin
            k++;
            if (!in_wait) begin
                check({t, "_req"}, 32'({stall, mem_req}), 32'b11);
                check({t, "_addr"}, mem_addr, {a[31:2], 2'b00});
                check({t, "_we"}, 32'(mem_we), 32'(is_store));
                if (is_store) begin
                    check({t, "_wmask"}, 32'(mem_wmask), 32'(exp_mask(f3, a)));
                    check({t, "_wdata"}, mem_wdata, exp_wdata(f3, d));
                end
                mem_ready  = (req_cnt == d_r);
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                if (mem_ready) begin
                    if (is_store) done = 1'b1;
                    else in_wait = 1'b1;
                end else if (k >= TO) begin
                    done = 1'b1; timed_out = 1'b1;
                end
                req_cnt++;
            end else begin
                check({t, "_wait"}, 32'({stall, mem_req}), 32'b10);
                mem_ready  = 1'($urandom);
                mem_rvalid = (wait_cnt == d_v);
                mem_rdata  = mem_rvalid ? rdata : $urandom;
                if (mem_rvalid) done = 1'b1;
                else if (k >= TO) begin
                    done = 1'b1; timed_out = 1'b1;
                end
                wait_cnt++;
            end
            step();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;

        ld_val = (is_load && !timed_out) ? exp_load(f3, a, rdata) : 32'd0;
        check({t, "_done_valid"}, 32'(wb_valid), 32'd1);
        check({t, "_done_err"}, 32'(mem_err), 32'(timed_out));
        check({t, "_done_rd"}, 32'(wb_rd), 32'(rd));
        check({t, "_done_we"}, 32'(wb_reg_write), 32'(is_load && !timed_out && rw));
        check({t, "_done_data"}, wb_mux_out, exp_wb(m2r, a, pc, ld_val));
        check({t, "_done_idle"}, 32'({stall, mem_req}), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  m2r;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
    } nm_vec_t;

    nm_vec_t vecs [5];

    initial begin
        int cyc;

        vecs[0] = '{2'b00, 32'h0000_1234, 32'h0000_0104, 5'd5,  1'b1, 32'h0000_1234};
        vecs[1] = '{2'b10, 32'hDEAD_0000, 32'h0000_0108, 5'd1,  1'b1, 32'h0000_0108};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_010C, 5'd31, 1'b1, 32'h0000_0000};
        vecs[3] = '{2'b01, 32'h0000_ABCD, 32'h0000_0110, 5'd7,  1'b0, 32'h0000_0000};
        vecs[4] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0114, 5'd0,  1'b0, 32'hFFFF_FFFE};

        rst = 1'b1; valid_in = 1'b0; load = 1'b0; store = 1'b0; func3 = '0; mem_to_reg = '0;
        alu_out = '0; op2_regfile_to_mem = '0; pc_plus4 = '0; rd_in = '0; reg_write_in = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Non-memory instructions, back-to-back every cycle.
        foreach (vecs[i]) begin
            drive(1'b0, 1'b0, 3'b000, vecs[i].m2r, vecs[i].alu, 32'h5555_AAAA, vecs[i].pc4, vecs[i].rd, vecs[i].rw);
            step();
            check($sformatf("nm%0d_valid", i), 32'(wb_valid), 32'd1);
            check($sformatf("nm%0d_data", i), wb_mux_out, vecs[i].exp_data);
            check($sformatf("nm%0d_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
            check($sformatf("nm%0d_we", i), 32'(wb_reg_write), 32'(vecs[i].rw));
            check($sformatf("nm%0d_stall", i), 32'({stall, mem_req}), 32'd0);
        end
        valid_in = 1'b0;
        step();
        check("nm_idle_valid", 32'(wb_valid), 32'd0);

        // LB from 0x103: ready on the third REQ cycle, data one cycle later.
        drive(1'b1, 1'b0, 3'b000, 2'b01, 32'h0000_0103, 32'h0, 32'h0000_0500, 5'd9, 1'b1);
        step();
        valid_in = 1'b0;
        check("lb_req", 32'({stall, mem_req, mem_we, wb_valid}), 32'b1100);
        check("lb_addr", mem_addr, 32'h0000_0100);
        step();
        check("lb_req_hold", 32'({stall, mem_req}), 32'b11);
        check("lb_addr_hold", mem_addr, 32'h0000_0100);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("lb_wait", 32'({stall, mem_req}), 32'b10);
        mem_rdata = 32'h80FF_0000;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("lb_done_valid", 32'({wb_valid, wb_reg_write, stall, mem_err}), 32'b1100);
        check("lb_done_data", wb_mux_out, 32'hFFFF_FF80);
        check("lb_done_rd", 32'(wb_rd), 32'd9);
        step();
        check("lb_after_valid", 32'(wb_valid), 32'd0);

        // SH to 0x0A: upper half lane, replicated data, no register write.
        drive(1'b0, 1'b1, 3'b001, 2'b00, 32'h0000_000A, 32'h0000_BEEF, 32'h0, 5'd3, 1'b1);
        step();
        valid_in = 1'b0;
        check("sh_we", 32'({mem_req, mem_we}), 32'b11);
        check("sh_wmask", 32'(mem_wmask), 32'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_addr", mem_addr, 32'h0000_0008);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("sh_done", 32'({wb_valid, wb_reg_write, mem_req}), 32'b100);
        check("sh_done_rd", 32'(wb_rd), 32'd3);

        // Load never handshaked: abort after TO cycles in REQ; stray rvalid ignored.
        drive(1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0200, 32'h0, 32'h0, 5'd7, 1'b1);
        step();
        valid_in = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        cyc = 0;
        while (!mem_err && cyc < 10) begin
            step();
            cyc++;
        end
        mem_rvalid = 1'b0;
        check("to_cycles", 32'(cyc), 32'(TO));
        check("to_done", 32'({mem_err, wb_valid, wb_reg_write, mem_req}), 32'b1100);
        check("to_data", wb_mux_out, 32'd0);
        step();
        check("to_err_pulse", 32'(mem_err), 32'd0);

        // Reset while waiting for read data; the late response must be ignored.
        drive(1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0300, 32'h0, 32'h0, 5'd4, 1'b1);
        step();
        valid_in = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("rst_pre_wait", 32'({stall, mem_req}), 32'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst_mid");
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero($sformatf("rst_late%0d", i));
        end
        mem_rvalid = 1'b0;

`ifdef MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0102, 32'h0, 32'h0, 5'd6, 1'b1);
        step();
        valid_in = 1'b0;
        check("mis_trap", 32'({mem_req, mem_err, wb_valid, wb_reg_write}), 32'b0110);
        step();
        check("mis_trap_after", 32'({mem_err, wb_valid}), 32'd0);
`else
        drive(1'b1, 1'b0, 3'b010, 2'b01, 32'h0000_0102, 32'h0, 32'h0, 5'd6, 1'b1);
        step();
        valid_in = 1'b0;
        check("mis_req", 32'(mem_req), 32'd1);
        check("mis_addr", mem_addr, 32'h0000_0100);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1122_3344;
        step();
        mem_rvalid = 1'b0;
        check("mis_done", 32'({wb_valid, wb_reg_write, mem_err}), 32'b110);
        check("mis_data", wb_mux_out, 32'h1122_3344);
`endif

        for (int i = 0; i < 60; i++) run_random(i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
